morse_tx: RTL and testbench
===========================

MORSE_TX -- requirements
Module: morse_tx

Interface
REQ-001 The block SHALL have parameter UNIT_CYCLES, default 4: clock cycles per Morse time unit, legal range 1..65535.
REQ-002 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 Port clrn, input, 1 bit: asynchronous active-low reset.
REQ-004 Port char_valid, input, 1 bit: char_code is valid this cycle.
REQ-005 Port char_code, input, 6 bits: 0-25 = A-Z, 26-35 = digits 0-9, 36 = word space, 37-63 = invalid.
REQ-006 Port char_ready, output, 1 bit: block can accept a character this cycle.
REQ-007 Port key_out, output, 1 bit: 1 = tone/mark, 0 = silence.
REQ-008 Port busy, output, 1 bit: high while a character or space is being sent.

Function
REQ-009 A character SHALL be accepted on a rising edge where char_valid and char_ready are both 1.
- char_code is latched at acceptance.
- char_code and char_valid are ignored at all other times.
REQ-010 char_ready SHALL be 1 only in IDLE; busy SHALL equal the inverse of char_ready.
REQ-011 The FSM SHALL use states IDLE, MARK, SYMGAP and CHARGAP.
- IDLE -> MARK on accepting a code 0-35.
- IDLE -> CHARGAP on accepting code 36.
- Codes 37-63 are consumed with busy high for exactly 1 cycle and key_out never asserted.
REQ-012 MARK SHALL last 1 unit for a dot and 3 units for a dash, with key_out = 1 for the whole state.
REQ-013 On leaving MARK:
- not the last symbol: go to SYMGAP for 1 unit, then MARK for the next symbol.
- last symbol: go to CHARGAP for 3 units, then IDLE.
REQ-014 Code 36 SHALL hold CHARGAP for 4 units, so that with the preceding 3-unit gap a word gap is 7 units.
REQ-015 One unit SHALL be exactly UNIT_CYCLES clock cycles. The prescaler restarts at every state entry, so each state lasts exactly units * UNIT_CYCLES cycles.
REQ-016 All outputs SHALL be registered.
- key_out rises on the first edge after acceptance.
- char_ready rises on the edge after the last CHARGAP cycle.
REQ-017 Back-to-back operation: a character presented while char_ready rises SHALL be accepted on that same edge, with no idle cycle inserted.
REQ-018 Symbol encoding SHALL follow standard ITU Morse.
- 1 to 5 symbols per character, sent first symbol first.
- Digits are 5 symbols each; 0 = five dashes.
REQ-019 The unit counter SHALL be 16 bits wide and the symbol index 3 bits wide. No counter may wrap during legal operation.

Reset
REQ-020 While clrn = 0, outputs SHALL be held asynchronously at: state IDLE, key_out = 0, char_ready = 1, busy = 0, all counters = 0.
REQ-021 A reset asserted mid-character SHALL abort transmission immediately; the aborted character is not resumed after reset.
REQ-022 After clrn deasserts, the first rising edge SHALL be able to accept a character.

Structure
REQ-023 Shared package morse_pkg SHALL hold:
- FSM state encoding.
- Character code constants (CODE_SPACE = 36, CODE_MAX_VALID = 36).
- Unit counts DOT_U = 1, DASH_U = 3, SYMGAP_U = 1, CHARGAP_U = 3, WORDGAP_EXTRA_U = 4.
REQ-024 Sub-module morse_rom SHALL be combinational.
- Input: char_code.
- Outputs: len (3 bits, 0 for invalid codes) and pattern (5 bits, 1 = dash, bit 4 = first symbol).
REQ-025 morse_tx SHALL instantiate morse_rom once and contain the FSM, prescaler and symbol index.

Verification (UNIT_CYCLES = 4, acceptance edge = cycle 0)
REQ-026 E (4): key_out 1 on cycles 1-4, 0 on cycles 5-16; char_ready = 1 at cycle 17.
REQ-027 A (0): key_out high 4 cycles, low 4, high 12, low 12; char_ready returns at cycle 33.
REQ-028 Digit 0 (26): five marks of 12 cycles separated by four 4-cycle gaps, then a 12-cycle gap; busy high for 88 cycles.
REQ-029 Space (36): key_out 0 and busy 1 for 16 cycles. Invalid code 50: busy 1 for 1 cycle, key_out stays 0.
REQ-030 Back-to-back: char_valid held at 1 with E then T. T's mark starts at cycle 18, lasts 12 cycles, and no idle cycle is inserted.
REQ-031 Reset: clrn pulsed low at cycle 6 of T (19).
- key_out goes 0 and char_ready goes 1 without waiting for a clock edge.
- After release, E transmits exactly as in REQ-026.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse transmitter: FSM state encoding,
// character code constants and the durations (in Morse units) of each element.
package morse_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MARK    = 2'd1;
  localparam logic [1:0] ST_SYMGAP  = 2'd2;
  localparam logic [1:0] ST_CHARGAP = 2'd3;

  localparam logic [5:0] CODE_SPACE     = 6'd36;
  localparam logic [5:0] CODE_MAX_VALID = 6'd36;

  localparam logic [2:0] DOT_U           = 3'd1;
  localparam logic [2:0] DASH_U          = 3'd3;
  localparam logic [2:0] SYMGAP_U        = 3'd1;
  localparam logic [2:0] CHARGAP_U       = 3'd3;
  localparam logic [2:0] WORDGAP_EXTRA_U = 3'd4;

  // Mark length in units for one symbol (1 = dash).
  function automatic logic [2:0] mark_units(input logic dash);
    return dash ? DASH_U : DOT_U;
  endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational character table: symbol count and dash/dot pattern per code.
// pattern is left-aligned: bit 4 is the first symbol sent, 1 = dash.
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0] char_code,
  output logic [2:0] len,
  output logic [4:0] pattern
);

  // ITU Morse lookup; anything that is not a letter or digit has no symbols.
  always_comb begin
    {len, pattern} = {3'd0, 5'b00000};
    case (char_code)
      6'd0:  {len, pattern} = {3'd2, 5'b01000}; // A .-
      6'd1:  {len, pattern} = {3'd4, 5'b10000}; // B -...
      6'd2:  {len, pattern} = {3'd4, 5'b10100}; // C -.-.
      6'd3:  {len, pattern} = {3'd3, 5'b10000}; // D -..
      6'd4:  {len, pattern} = {3'd1, 5'b00000}; // E .
      6'd5:  {len, pattern} = {3'd4, 5'b00100}; // F ..-.
      6'd6:  {len, pattern} = {3'd3, 5'b11000}; // G --.
      6'd7:  {len, pattern} = {3'd4, 5'b00000}; // H ....
      6'd8:  {len, pattern} = {3'd2, 5'b00000}; // I ..
      6'd9:  {len, pattern} = {3'd4, 5'b01110}; // J .---
      6'd10: {len, pattern} = {3'd3, 5'b10100}; // K -.-
      6'd11: {len, pattern} = {3'd4, 5'b01000}; // L .-..
      6'd12: {len, pattern} = {3'd2, 5'b11000}; // M --
      6'd13: {len, pattern} = {3'd2, 5'b10000}; // N -.
      6'd14: {len, pattern} = {3'd3, 5'b11100}; // O ---
      6'd15: {len, pattern} = {3'd4, 5'b01100}; // P .--.
      6'd16: {len, pattern} = {3'd4, 5'b11010}; // Q --.-
      6'd17: {len, pattern} = {3'd3, 5'b01000}; // R .-.
      6'd18: {len, pattern} = {3'd3, 5'b00000}; // S ...
      6'd19: {len, pattern} = {3'd1, 5'b10000}; // T -
      6'd20: {len, pattern} = {3'd3, 5'b00100}; // U ..-
      6'd21: {len, pattern} = {3'd4, 5'b00010}; // V ...-
      6'd22: {len, pattern} = {3'd3, 5'b01100}; // W .--
      6'd23: {len, pattern} = {3'd4, 5'b10010}; // X -..-
      6'd24: {len, pattern} = {3'd4, 5'b10110}; // Y -.--
      6'd25: {len, pattern} = {3'd4, 5'b11000}; // Z --..
      6'd26: {len, pattern} = {3'd5, 5'b11111}; // 0
      6'd27: {len, pattern} = {3'd5, 5'b01111}; // 1
      6'd28: {len, pattern} = {3'd5, 5'b00111}; // 2
      6'd29: {len, pattern} = {3'd5, 5'b00011}; // 3
      6'd30: {len, pattern} = {3'd5, 5'b00001}; // 4
      6'd31: {len, pattern} = {3'd5, 5'b00000}; // 5
      6'd32: {len, pattern} = {3'd5, 5'b10000}; // 6
      6'd33: {len, pattern} = {3'd5, 5'b11000}; // 7
      6'd34: {len, pattern} = {3'd5, 5'b11100}; // 8
      6'd35: {len, pattern} = {3'd5, 5'b11110}; // 9
      default: {len, pattern} = {3'd0, 5'b00000};
    endcase
  end

endmodule

// File: rtl/morse_tx.sv
// Morse code keyer: accepts one character code at a time and keys it out
// as marks and gaps timed in units of UNIT_CYCLES clock cycles.
module morse_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       char_valid,
  input  logic [5:0] char_code,
  output logic       char_ready,
  output logic       key_out,
  output logic       busy
);

  localparam logic [15:0] UNIT_LAST = 16'(UNIT_CYCLES - 1);

  logic [1:0]  state, state_n;
  logic [15:0] presc, presc_n;
  logic [2:0]  units, units_n;
  logic [2:0]  sym_idx, sym_idx_n;
  logic [2:0]  len_q, len_n;
  logic [4:0]  pat_q, pat_n;
  logic [2:0]  rom_len;
  logic [4:0]  rom_pat;
  logic        accept, unit_end, unit_done;
  logic [2:0]  next_idx;

  morse_rom u_rom (
    .char_code (char_code),
    .len       (rom_len),
    .pattern   (rom_pat)
  );

  // Symbol idx of a left-aligned pattern, as a dash flag.
  function automatic logic sym_is_dash(input logic [4:0] pat, input logic [2:0] idx);
    logic [4:0] shifted;
    shifted = pat << idx;
    return shifted[4];
  endfunction

  assign accept    = char_valid & char_ready;
  assign unit_end  = (presc == UNIT_LAST);
  assign unit_done = unit_end && (units == 3'd1);
  assign next_idx  = sym_idx + 3'd1;

  // Next-state logic: the prescaler restarts on every state entry.
  always_comb begin
    state_n   = state;
    presc_n   = unit_end ? 16'd0 : presc + 16'd1;
    units_n   = unit_end ? units - 3'd1 : units;
    sym_idx_n = sym_idx;
    len_n     = len_q;
    pat_n     = pat_q;
    case (state)
      ST_IDLE: begin
        presc_n = 16'd0;
        units_n = units;
        if (accept) begin
          len_n     = rom_len;
          pat_n     = rom_pat;
          sym_idx_n = 3'd0;
          if (char_code < CODE_SPACE) begin
            state_n = ST_MARK;
            units_n = mark_units(rom_pat[4]);
          end else if (char_code == CODE_SPACE) begin
            state_n = ST_CHARGAP;
            units_n = WORDGAP_EXTRA_U;
          end else begin
            // Invalid code: a zero-length gap makes busy pulse for one cycle.
            state_n = ST_CHARGAP;
            units_n = 3'd0;
          end
        end
      end
      ST_MARK: begin
        if (unit_done) begin
          presc_n = 16'd0;
          if (next_idx < len_q) begin
            state_n   = ST_SYMGAP;
            units_n   = SYMGAP_U;
            sym_idx_n = next_idx;
          end else begin
            state_n = ST_CHARGAP;
            units_n = CHARGAP_U;
          end
        end
      end
      ST_SYMGAP: begin
        if (unit_done) begin
          presc_n = 16'd0;
          state_n = ST_MARK;
          units_n = mark_units(sym_is_dash(pat_q, sym_idx));
        end
      end
      default: begin
        if (units == 3'd0 || unit_done) begin
          state_n   = ST_IDLE;
          presc_n   = 16'd0;
          units_n   = 3'd0;
          sym_idx_n = 3'd0;
        end
      end
    endcase
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= ST_IDLE;
      presc      <= 16'd0;
      units      <= 3'd0;
      sym_idx    <= 3'd0;
      len_q      <= 3'd0;
      pat_q      <= 5'd0;
      key_out    <= 1'b0;
      char_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      presc      <= presc_n;
      units      <= units_n;
      sym_idx    <= sym_idx_n;
      len_q      <= len_n;
      pat_q      <= pat_n;
      key_out    <= (state_n == ST_MARK);
      char_ready <= (state_n == ST_IDLE);
      busy       <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_morse_tx.sv
// Testbench for morse_tx with UNIT_CYCLES = 4: table of characters with
// hand-written Morse patterns and busy lengths, plus back-to-back and reset sequences.
module tb_morse_tx;

  logic       clk;
  logic       clrn;
  logic       char_valid;
  logic [5:0] char_code;
  logic       char_ready;
  logic       key_out;
  logic       busy;

  int tests = 0;
  int fails = 0;

  morse_tx #(.UNIT_CYCLES(4)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_ready (char_ready),
    .key_out    (key_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] code;
    int         len;
    logic [4:0] pat;
    int         busy_cyc;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Send one character from idle and compare the key trace and busy length.
  task automatic run_char(input logic [5:0] code, input int elen, input logic [4:0] epat,
                          input int ebusy);
    logic exp_key[$];
    logic e;
    int   nbusy;
    int   bad_cyc;
    logic bad_act;
    int   waits;
    exp_key = {};
    for (int i = 0; i < elen; i++) begin
      repeat (epat[4 - i] ? 12 : 4) exp_key.push_back(1'b1);
      if (i < elen - 1) repeat (4) exp_key.push_back(1'b0);
    end
    if (elen > 0) repeat (12) exp_key.push_back(1'b0);
    while (exp_key.size() < ebusy) exp_key.push_back(1'b0);

    waits = 0;
    @(negedge clk);
    while (!char_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    char_valid = 1'b1;
    char_code  = code;
    @(negedge clk);
    char_valid = 1'b0;
    char_code  = 6'd19;

    nbusy   = 0;
    bad_cyc = -1;
    bad_act = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      e = (c - 1 < exp_key.size()) ? exp_key[c - 1] : 1'b0;
      if (key_out !== e && bad_cyc < 0) begin
        bad_cyc = c;
        bad_act = key_out;
      end
      if (!busy) break;
      nbusy++;
      @(negedge clk);
    end
    tests++;
    if (bad_cyc >= 0) begin
      fails++;
      $display("FAIL key_trace code %0d: cycle %0d key_out %0b, expected %0b",
               code, bad_cyc, bad_act, ~bad_act);
    end
    check($sformatf("busy_len code %0d", code), nbusy, ebusy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{6'd4,  1, 5'b00000, 16};  // E
    vecs[1]  = '{6'd19, 1, 5'b10000, 24};  // T
    vecs[2]  = '{6'd0,  2, 5'b01000, 32};  // A
    vecs[3]  = '{6'd13, 2, 5'b10000, 32};  // N
    vecs[4]  = '{6'd18, 3, 5'b00000, 32};  // S
    vecs[5]  = '{6'd14, 3, 5'b11100, 56};  // O
    vecs[6]  = '{6'd16, 4, 5'b11010, 64};  // Q
    vecs[7]  = '{6'd25, 4, 5'b11000, 56};  // Z
    vecs[8]  = '{6'd26, 5, 5'b11111, 88};  // 0
    vecs[9]  = '{6'd31, 5, 5'b00000, 48};  // 5
    vecs[10] = '{6'd35, 5, 5'b11110, 80};  // 9
    vecs[11] = '{6'd36, 0, 5'b00000, 16};  // word space
    vecs[12] = '{6'd50, 0, 5'b00000, 1};   // invalid
    vecs[13] = '{6'd63, 0, 5'b00000, 1};   // invalid

    clrn       = 1'b1;
    char_valid = 1'b0;
    char_code  = 6'd0;
    #1 clrn = 1'b0;
    #2;
    check("reset key_out", key_out, 0);
    check("reset char_ready", char_ready, 1);
    check("reset busy", busy, 0);
    @(posedge clk);
    #2 clrn = 1'b1;

    for (int v = 0; v < 14; v++)
      run_char(vecs[v].code, vecs[v].len, vecs[v].pat, vecs[v].busy_cyc);

    // Back-to-back: valid held high, E followed immediately by T.
    begin
      int   bad;
      logic e;
      bad = 0;
      @(negedge clk);
      char_valid = 1'b1;
      char_code  = 6'd4;
      @(negedge clk);
      char_code = 6'd19;
      for (int c = 1; c <= 32; c++) begin
        e = (c <= 4) || (c >= 18 && c <= 29);
        if (key_out !== e && bad == 0) begin
          bad = c;
          $display("FAIL b2b_key: cycle %0d key_out %0b, expected %0b", c, key_out, e);
        end
        if (c == 17) check("b2b ready at 17", char_ready, 1);
        if (c == 18) begin
          check("b2b ready at 18", char_ready, 0);
          char_valid = 1'b0;
        end
        @(negedge clk);
      end
      tests++;
      if (bad != 0) fails++;
      for (int w = 0; w < 100 && busy; w++) @(negedge clk);
      check("b2b idle after T", busy, 0);
    end

    // Reset in the middle of T's mark.
    @(negedge clk);
    char_valid = 1'b1;
    char_code  = 6'd19;
    @(negedge clk);
    char_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid-T key_out", key_out, 1);
    clrn = 1'b0;
    #1;
    check("async reset key_out", key_out, 0);
    check("async reset char_ready", char_ready, 1);
    check("async reset busy", busy, 0);
    @(posedge clk);
    #2 clrn = 1'b1;
    run_char(6'd4, 1, 5'b00000, 16);
    repeat (3) @(negedge clk);
    check("idle after E key_out", key_out, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
